cdc_handshake_src: RTL and testbench

//  Source (sending) end of a 4-phase req/ack clock-domain-crossing handshake.
//  - Accepts a WIDTH-bit word from local logic and holds it stable on data_o.
//  - Raises req_o and waits for the far-domain ack, which it brings in through
//    its own STAGES-deep flop chain.
//  - Completes the return-to-zero phase, then accepts the next word.

---
 rtl/cdc_handshake_src.sv | 103 ++++++++++
 tb/tb_cdc_handshake_src.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_src.sv
// Source end of a 4-phase req/ack CDC handshake: holds a word on data_o,
// raises req_o, waits for the synchronized ack, then returns to zero.
module cdc_handshake_src #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_async_i,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [STAGES-1:0] sync_q, sync_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_sync;

  assign ack_sync = sync_q[STAGES-1];
  assign ready_o  = (state_q == IDLE) & ~ack_sync & ~rst;
  assign req_o    = req_q;
  assign data_o   = data_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

  // Next-state and registered-output logic; ack always wins over timeout.
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[STAGES-2:0], ack_async_i};
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          data_d  = data_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_sync) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = REL;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Directed bench for cdc_handshake_src (WIDTH=8, STAGES=2, TIMEOUT=10) with
// a data scoreboard fed on acceptance and drained on each req_o rise.
module tb_cdc_handshake_src;

  logic       clk;
  logic       rst;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       req_o;
  logic [7:0] data_o;
  logic       ack_async_i;
  logic       done_o;
  logic       err_o;

  cdc_handshake_src #(.WIDTH(8), .STAGES(2), .TIMEOUT(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_async_i (ack_async_i),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_fail;
  logic [7:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one word while ready, take the accepting edge, then check the payload.
  task automatic accept(input logic [7:0] w);
    logic [7:0] exp;
    check("ready_before_accept", 32'(ready_o), 32'd1);
    data_i  = w;
    valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    sb_q.push_back(w);
    exp = sb_q.pop_front();
    check("req_after_accept", 32'(req_o), 32'd1);
    check("data_after_accept", 32'(data_o), 32'(exp));
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (ready_o) break;
      cyc();
    end
    check(tag, 32'(ready_o), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (done_o) break;
    end
    check(tag, 32'(done_o), 32'd1);
  endtask

  initial begin
    logic [7:0] words [3];
    logic [7:0] exp_w;
    logic       acc;
    logic       prev_req;
    int         idx, nreq, ndone, nerr, bad_ready, hi, err_at, ready_at;
    int         acc_cyc [3];

    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    valid_i     = 1'b0;
    data_i      = 8'h00;
    ack_async_i = 1'b0;

    // Reset held for three cycles
    cyc(); cyc(); cyc();
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ready_o), 32'd1);

    // Single transfer, responder acks two cycles after req rises
    accept(8'hA5);
    cyc(); cyc();
    ack_async_i = 1'b1;
    cyc(); cyc();
    check("single_req_hold", 32'(req_o), 32'd1);
    check("single_done_early", 32'(done_o), 32'd0);
    cyc();
    check("single_req_fall", 32'(req_o), 32'd0);
    check("single_done", 32'(done_o), 32'd1);
    check("single_data_hold", 32'(data_o), 32'hA5);
    ack_async_i = 1'b0;
    cyc();
    check("single_done_pulse", 32'(done_o), 32'd0);
    check("single_ready_rel0", 32'(ready_o), 32'd0);
    cyc();
    check("single_ready_rel1", 32'(ready_o), 32'd0);
    cyc();
    check("single_ready_back", 32'(ready_o), 32'd1);

    // Back-to-back words with an instant far-side responder
    words     = '{8'h01, 8'h02, 8'h03};
    idx       = 0;
    nreq      = 0;
    ndone     = 0;
    nerr      = 0;
    bad_ready = 0;
    prev_req  = req_o;
    acc_cyc   = '{0, 0, 0};
    valid_i   = 1'b1;
    data_i    = words[0];
    for (int c = 0; c < 80; c++) begin
      if (idx == 3 && ndone == 3 && ready_o) break;
      acc = valid_i & ready_o;
      cyc();
      if (acc) begin
        sb_q.push_back(data_i);
        acc_cyc[idx] = c;
        idx++;
        if (idx < 3) data_i = words[idx];
        else valid_i = 1'b0;
      end
      if (req_o && !prev_req) begin
        nreq++;
        exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        check("b2b_data", 32'(data_o), 32'(exp_w));
      end
      if (req_o && ready_o) bad_ready++;
      if (done_o) ndone++;
      if (err_o) nerr++;
      prev_req    = req_o;
      ack_async_i = req_o;
    end
    valid_i = 1'b0;
    check("b2b_accepts", 32'(idx), 32'd3);
    check("b2b_req_pulses", 32'(nreq), 32'd3);
    check("b2b_done_pulses", 32'(ndone), 32'd3);
    check("b2b_err_pulses", 32'(nerr), 32'd0);
    check("b2b_ready_in_req", 32'(bad_ready), 32'd0);
    check("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
    check("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd7);
    check("b2b_sb_empty", 32'(sb_q.size()), 32'd0);
    check("b2b_last_data", 32'(data_o), 32'h03);

    // Timeout with ack tied low
    ack_async_i = 1'b0;
    wait_ready("to_ready_start");
    accept(8'h5A);
    hi       = 1;
    nerr     = 0;
    ndone    = 0;
    err_at   = -1;
    ready_at = -1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (req_o) hi++;
      if (err_o) begin
        nerr++;
        err_at = c;
      end
      if (done_o) ndone++;
      if (ready_o && ready_at < 0) ready_at = c;
    end
    check("to_req_cycles", 32'(hi), 32'd10);
    check("to_err_pulses", 32'(nerr), 32'd1);
    check("to_done_pulses", 32'(ndone), 32'd0);
    check("to_ready_after_err", 32'(ready_at), 32'(err_at + 1));
    check("to_data_hold", 32'(data_o), 32'h5A);

    // Ack reaches the FSM in the same cycle the count hits TIMEOUT-1
    accept(8'hC3);
    for (int k = 0; k < 7; k++) cyc();
    ack_async_i = 1'b1;
    cyc();
    check("tie_req_hold_a", 32'(req_o), 32'd1);
    cyc();
    check("tie_req_hold_b", 32'(req_o), 32'd1);
    check("tie_done_early", 32'(done_o), 32'd0);
    cyc();
    check("tie_done", 32'(done_o), 32'd1);
    check("tie_err", 32'(err_o), 32'd0);
    check("tie_req_fall", 32'(req_o), 32'd0);
    ack_async_i = 1'b0;
    cyc();
    check("tie_err_after", 32'(err_o), 32'd0);
    wait_ready("tie_ready_back");

    // Reset in the middle of REQ while the far side is acking
    accept(8'h3C);
    ack_async_i = 1'b1;
    rst         = 1'b1;
    cyc();
    check("midrst_req", 32'(req_o), 32'd0);
    check("midrst_data", 32'(data_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    rst = 1'b0;
    cyc(); cyc();
    check("midrst_ready_ack_a", 32'(ready_o), 32'd0);
    check("midrst_no_done", 32'(done_o), 32'd0);
    cyc();
    check("midrst_ready_ack_b", 32'(ready_o), 32'd0);
    ack_async_i = 1'b0;
    cyc();
    check("midrst_ready_ack_c", 32'(ready_o), 32'd0);
    cyc();
    check("midrst_ready_back", 32'(ready_o), 32'd1);

    // Normal transfer after the aborted one
    accept(8'h96);
    ack_async_i = 1'b1;
    wait_done("post_done");
    check("post_data", 32'(data_o), 32'h96);
    check("post_err", 32'(err_o), 32'd0);
    ack_async_i = 1'b0;
    wait_ready("post_ready");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
